// File: rtl/chimera_cluster_pwr_ctrl_if.sv
// APB completer bundle for the per-cluster power controller's register window.
interface chimera_cluster_pwr_ctrl_if #(
  parameter int unsigned AddrWidth = 32
);
  logic [AddrWidth-1:0] paddr;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [31:0]          pwdata;
  logic                 pready;
  logic [31:0]          prdata;
  logic                 pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/chimera_cluster_pwr_ctrl.sv
// Per-cluster isolate / clock-gate / soft-reset sequencer behind an APB register window.
// Optional isolation-ack timeout with error flag: define CHIMERA_PWR_TIMEOUT_EN.
module chimera_cluster_pwr_ctrl #(
  parameter int unsigned NumClusters   = 5,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned RstCycles     = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter bit          ResetOn       = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  chimera_cluster_pwr_ctrl_if.slave apb,
  output logic [NumClusters-1:0] cluster_clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_o,
  output logic [NumClusters-1:0] cluster_isolate_o,
  input  logic [NumClusters-1:0] cluster_isolated_i
);

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_ISO  = 3'd1,
    ST_OFF  = 3'd2,
    ST_RST  = 3'd3,
    ST_WAKE = 3'd4
  } state_e;

  localparam int unsigned IdxMsb = (AddrWidth > 6) ? 5 : AddrWidth - 1;
  localparam int unsigned CntW   = $clog2(RstCycles + 1);

  state_e                 state_q [NumClusters];
  state_e                 state_d [NumClusters];
  logic [CntW-1:0]        rst_cnt_q [NumClusters];
  logic [NumClusters-1:0] target_q, pend_q, rearm_q, err, to_hit, rst_last;
  logic [NumClusters-1:0] wr_sel, srst_wr;
  logic                   access, wr_en, idx_ok;
  logic [3:0]             idx;

  // ---------------------------------------------------------------- APB decode
  assign access = apb.psel & apb.penable;
  assign idx    = 4'(apb.paddr[IdxMsb:2]);
  assign idx_ok = ({1'b0, idx} < 5'(NumClusters));
  assign wr_en  = access & apb.pwrite & idx_ok;
  assign apb.pready = 1'b1;

  always_comb begin
    wr_sel = '0;
    for (int c = 0; c < NumClusters; c++) wr_sel[c] = wr_en && (idx == 4'(c));
  end

  assign srst_wr = wr_sel & {NumClusters{apb.pwdata[1]}};

  always_comb begin
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    if (access) begin
      if (!idx_ok) begin
        apb.pslverr = 1'b1;
      end else begin
        for (int c = 0; c < NumClusters; c++) begin
          if (idx == 4'(c)) apb.prdata = {25'd0, state_q[c], 1'b0, err[c], pend_q[c], target_q[c]};
        end
      end
    end
  end

  // Only the selected data bits and address bits [5:2] carry meaning.
  logic unused_bits;
  assign unused_bits = ^{apb.pwdata[31:3], apb.paddr};

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumClusters; c++) begin
      // NOTE: reset is synchronous, so it lives inside the clocked block and wins over every other update.
      if (rst_i) state_q[c] <= ResetOn ? ST_RUN : ST_OFF;
      else       state_q[c] <= state_d[c];
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    rst_last = '0;
    for (int c = 0; c < NumClusters; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        ST_RUN:  if (!target_q[c] || pend_q[c]) state_d[c] = ST_ISO;
        ST_ISO:  if (cluster_isolated_i[c] || to_hit[c]) state_d[c] = ST_OFF;
        ST_OFF: begin
          if (pend_q[c])        state_d[c] = ST_RST;
          else if (target_q[c]) state_d[c] = ST_WAKE;
        end
        ST_RST: begin
          if (rst_cnt_q[c] == CntW'(RstCycles - 1)) begin
            rst_last[c] = 1'b1;
            state_d[c]  = target_q[c] ? ST_WAKE : ST_OFF;
          end
        end
        ST_WAKE: if (!cluster_isolated_i[c] || to_hit[c]) state_d[c] = ST_RUN;
        default: state_d[c] = ST_OFF;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    cluster_clk_en_o  = '0;
    cluster_rst_o     = '0;
    cluster_isolate_o = '1;
    for (int c = 0; c < NumClusters; c++) begin
      case (state_q[c])
        ST_RUN, ST_WAKE: begin
          cluster_clk_en_o[c]  = 1'b1;
          cluster_isolate_o[c] = 1'b0;
        end
        ST_ISO: cluster_clk_en_o[c] = 1'b1;
        ST_RST: begin
          cluster_clk_en_o[c] = 1'b1;
          cluster_rst_o[c]    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- control fields, RST counter
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumClusters; c++) begin
      if (rst_i) begin
        target_q[c]  <= ResetOn;
        pend_q[c]    <= 1'b0;
        rearm_q[c]   <= 1'b0;
        rst_cnt_q[c] <= '0;
      end else begin
        if (wr_sel[c]) target_q[c] <= apb.pwdata[0];
        // A soft-reset request arriving mid-pass survives the end-of-pass clear.
        if (rst_last[c])     pend_q[c] <= rearm_q[c] | srst_wr[c];
        else if (srst_wr[c]) pend_q[c] <= 1'b1;
        if (state_q[c] == ST_RST && !rst_last[c]) rearm_q[c] <= rearm_q[c] | srst_wr[c];
        else                                      rearm_q[c] <= 1'b0;
        if (state_q[c] != ST_RST)   rst_cnt_q[c] <= '0;
        else if (rst_cnt_q[c] != '1) rst_cnt_q[c] <= rst_cnt_q[c] + 1'b1;
      end
    end
  end

`ifdef CHIMERA_PWR_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] to_cnt_q [NumClusters];

  always_comb begin
    to_hit = '0;
    for (int c = 0; c < NumClusters; c++) begin
      to_hit[c] = (to_cnt_q[c] == ToW'(TimeoutCycles - 1)) &&
                  ((state_q[c] == ST_ISO  && !cluster_isolated_i[c]) ||
                   (state_q[c] == ST_WAKE &&  cluster_isolated_i[c]));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumClusters; c++) begin
      if (rst_i || !(state_q[c] == ST_ISO || state_q[c] == ST_WAKE)) to_cnt_q[c] <= '0;
      else if (to_cnt_q[c] != '1)                                    to_cnt_q[c] <= to_cnt_q[c] + 1'b1;
      // Hardware set beats a same-cycle software clear.
      if (rst_i)                              err[c] <= 1'b0;
      else if (to_hit[c])                     err[c] <= 1'b1;
      else if (wr_sel[c] && apb.pwdata[2])    err[c] <= 1'b0;
    end
  end
`else
  assign to_hit = '0;
  assign err    = '0;

  logic unused_timeout;
  assign unused_timeout = ^{TimeoutCycles, apb.pwdata[2]};
`endif

endmodule

// File: tb/tb_chimera_cluster_pwr_ctrl.sv
// Scenario bench for chimera_cluster_pwr_ctrl: APB reads scored against a queue of expected words.
module tb_chimera_cluster_pwr_ctrl;
  localparam int NC = 5;
  localparam int RC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chimera_cluster_pwr_ctrl_if #(.AddrWidth(32)) apb ();

  logic [NC-1:0] clk_en, crst, iso, isolated;
  logic [NC-1:0] auto_ack = '0;
  logic [NC-1:0] man_ack  = '0;
  logic [NC-1:0] ack_dly  = '0;

  // Isolation cells either answer one cycle after the request or are driven by hand.
  always @(posedge clk) ack_dly <= iso;
  assign isolated = (auto_ack & ack_dly) | (~auto_ack & man_ack);

  chimera_cluster_pwr_ctrl #(
    .NumClusters(NC), .AddrWidth(32), .RstCycles(RC), .TimeoutCycles(1024), .ResetOn(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .apb(apb),
    .cluster_clk_en_o(clk_en), .cluster_rst_o(crst),
    .cluster_isolate_o(iso), .cluster_isolated_i(isolated)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd, exp;
  logic        se;
  bit          ok;

  task automatic apb_xfer(input int idx, input bit write, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic slverr);
    @(negedge clk);
    apb.paddr = 32'(idx * 4); apb.pwrite = write; apb.pwdata = wdata;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    rdata  = apb.prdata;
    slverr = apb.pslverr;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  // which: 0 = isolate, 1 = cluster reset, other = clock enable
  task automatic wait_sig(input int which, input int c, input logic val, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = (iso[c] === val);
        1:       hit = (crst[c] === val);
        default: hit = (clk_en[c] === val);
      endcase
      if (hit) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({clk_en, crst, iso} !== {5'h1f, 5'h00, 5'h00}) begin
      n_bad++; $display("FAIL reset_outs: got %h want %h", {clk_en, crst, iso}, {5'h1f, 5'h00, 5'h00});
    end
    n_total++;
    if ({apb.prdata, apb.pslverr} !== 33'd0) begin
      n_bad++; $display("FAIL reset_apb: got %h want 0", {apb.prdata, apb.pslverr});
    end
    rst = 1'b0;
    exp_q.push_back(32'h01);
    apb_xfer(0, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL reset_reg0: got %h want %h", rd, exp); end
  endtask

  task automatic test_power_down;
    apb_xfer(2, 1'b1, 32'h0, rd, se);
    n_total++;
    if (iso[2] !== 1'b0) begin n_bad++; $display("FAIL pd_iso_early: got %b want 0", iso[2]); end
    @(negedge clk);
    n_total++;
    if (iso[2] !== 1'b1) begin n_bad++; $display("FAIL pd_iso_latency: got %b want 1", iso[2]); end
    repeat (3) @(negedge clk);
    man_ack[2] = 1'b1;
    #1;
    n_total++;
    if (clk_en[2] !== 1'b1) begin n_bad++; $display("FAIL pd_clk_hold: got %b want 1", clk_en[2]); end
    @(negedge clk);
    n_total++;
    if (clk_en !== 5'b11011) begin n_bad++; $display("FAIL pd_clk_gate: got %b want 11011", clk_en); end
    exp_q.push_back(32'h20);
    apb_xfer(2, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL pd_reg2_off: got %h want %h", rd, exp); end
    apb_xfer(2, 1'b1, 32'h1, rd, se);
    wait_sig(0, 2, 1'b0, 10, ok);
    n_total++;
    if (!ok || clk_en[2] !== 1'b1) begin
      n_bad++; $display("FAIL pd_wake: got iso=%b clk_en=%b want iso=0 clk_en=1", iso[2], clk_en[2]);
    end
    exp_q.push_back(32'h41);
    apb_xfer(2, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL pd_reg2_wake: got %h want %h", rd, exp); end
    man_ack[2] = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h01);
    apb_xfer(2, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL pd_reg2_run: got %h want %h", rd, exp); end
  endtask

  task automatic test_target_toggle;
    apb_xfer(2, 1'b1, 32'h0, rd, se);
    apb_xfer(2, 1'b1, 32'h1, rd, se);
    exp_q.push_back(32'h11);
    apb_xfer(2, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL tog_still_iso: got %h want %h", rd, exp); end
    man_ack[2] = 1'b1;
    wait_sig(0, 2, 1'b0, 10, ok);
    exp_q.push_back(32'h41);
    apb_xfer(2, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (!ok || rd !== exp) begin n_bad++; $display("FAIL tog_wake: got %h want %h", rd, exp); end
    man_ack[2] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_soft_reset;
    int hi = 0;
    int rises = 0;
    bit outs_ok = 1'b1;
    logic prev = 1'b0;
    auto_ack[1] = 1'b1;
    apb_xfer(1, 1'b1, 32'h3, rd, se);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (crst[1]) begin
        hi++;
        if (!(clk_en[1] && iso[1])) outs_ok = 1'b0;
      end
      if (crst[1] && !prev) rises++;
      prev = crst[1];
    end
    n_total++;
    if (hi !== RC || rises !== 1) begin
      n_bad++; $display("FAIL srst_pulse: got cycles=%0d pulses=%0d want cycles=%0d pulses=1", hi, rises, RC);
    end
    n_total++;
    if (!outs_ok) begin n_bad++; $display("FAIL srst_outs: got clk_en/iso low in RST want both 1"); end
    exp_q.push_back(32'h01);
    apb_xfer(1, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL srst_reg1: got %h want %h", rd, exp); end
    auto_ack[1] = 1'b0;
  endtask

  task automatic test_back_to_back;
    int hi = 0;
    int rises = 0;
    logic prev = 1'b0;
    bit hit;
    logic [31:0] d;
    logic e;
    auto_ack[3] = 1'b1;
    apb_xfer(3, 1'b1, 32'h3, rd, se);
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          @(negedge clk);
          if (crst[3]) hi++;
          if (crst[3] && !prev) rises++;
          prev = crst[3];
        end
      end
      begin
        wait_sig(1, 3, 1'b1, 40, hit);
        apb_xfer(3, 1'b1, 32'h3, d, e);
      end
    join
    n_total++;
    if (hi !== 2 * RC || rises !== 2) begin
      n_bad++; $display("FAIL rearm_pulses: got cycles=%0d pulses=%0d want cycles=%0d pulses=2", hi, rises, 2 * RC);
    end
    exp_q.push_back(32'h01);
    apb_xfer(3, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL rearm_reg3: got %h want %h", rd, exp); end
    auto_ack[3] = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [14:0] snap;
    snap = {clk_en, crst, iso};
    exp_q.push_back(32'h0);
    apb_xfer(7, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp || se !== 1'b1) begin n_bad++; $display("FAIL oor_read7: got %h/%b want %h/1", rd, se, exp); end
    apb_xfer(NC, 1'b0, '0, rd, se);
    n_total++;
    if (se !== 1'b1) begin n_bad++; $display("FAIL oor_read_edge: got pslverr=%b want 1", se); end
    exp_q.push_back(32'h01);
    apb_xfer(NC - 1, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp || se !== 1'b0) begin n_bad++; $display("FAIL oor_read_last: got %h/%b want %h/0", rd, se, exp); end
    apb_xfer(7, 1'b1, 32'h2, rd, se);
    apb_xfer(NC, 1'b1, 32'h0, rd, se);
    repeat (6) @(negedge clk);
    n_total++;
    if ({clk_en, crst, iso} !== snap) begin
      n_bad++; $display("FAIL oor_write: got %h want %h", {clk_en, crst, iso}, snap);
    end
  endtask

  task automatic test_reset_mid_rst;
    auto_ack[0] = 1'b1;
    apb_xfer(0, 1'b1, 32'h3, rd, se);
    wait_sig(1, 0, 1'b1, 40, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL mid_rst_enter: got rst_o[0]=%b want 1", crst[0]); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({clk_en, crst, iso} !== {5'h1f, 5'h00, 5'h00}) begin
      n_bad++; $display("FAIL mid_rst_outs: got %h want %h", {clk_en, crst, iso}, {5'h1f, 5'h00, 5'h00});
    end
    rst = 1'b0;
    auto_ack[0] = 1'b0;
    repeat (20) @(negedge clk);
    exp_q.push_back(32'h01);
    apb_xfer(0, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp || crst[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_reg0: got %h rst=%b want %h rst=0", rd, crst[0], exp);
    end
  endtask

`ifdef CHIMERA_PWR_TIMEOUT_EN
  task automatic test_timeout;
    apb_xfer(4, 1'b1, 32'h0, rd, se);
    repeat (1000) @(negedge clk);
    exp_q.push_back(32'h10);
    apb_xfer(4, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL to_before: got %h want %h", rd, exp); end
    repeat (40) @(negedge clk);
    exp_q.push_back(32'h24);
    apb_xfer(4, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL to_iso: got %h want %h", rd, exp); end
    apb_xfer(4, 1'b1, 32'h4, rd, se);
    exp_q.push_back(32'h20);
    apb_xfer(4, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL to_clear: got %h want %h", rd, exp); end
    man_ack[4] = 1'b1;
    apb_xfer(4, 1'b1, 32'h1, rd, se);
    repeat (1040) @(negedge clk);
    exp_q.push_back(32'h05);
    apb_xfer(4, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL to_wake: got %h want %h", rd, exp); end
    man_ack[4] = 1'b0;
    apb_xfer(4, 1'b1, 32'h5, rd, se);
    exp_q.push_back(32'h01);
    apb_xfer(4, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL to_final: got %h want %h", rd, exp); end
  endtask
`else
  task automatic test_no_timeout;
    apb_xfer(4, 1'b1, 32'h4, rd, se);
    repeat (1100) @(negedge clk);
    exp_q.push_back(32'h10);
    apb_xfer(4, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL nto_iso_wait: got %h want %h", rd, exp); end
    man_ack[4] = 1'b1;
    apb_xfer(4, 1'b1, 32'h1, rd, se);
    man_ack[4] = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h01);
    apb_xfer(4, 1'b0, '0, rd, se);
    exp = exp_q.pop_front(); n_total++;
    if (rd !== exp) begin n_bad++; $display("FAIL nto_final: got %h want %h", rd, exp); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test want finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;
    test_reset();
    test_power_down();
    test_target_toggle();
    test_soft_reset();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_rst();
`ifdef CHIMERA_PWR_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_total++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
